regfile_writeback_queue: RTL and testbench

- Writer side of the 32×32 register file.
- Collects write-back results from two producers:
  - Source A: the single-cycle ALU path, high priority.
  - Source B: the multi-cycle load/mul path, low priority.
- Buffers them in a DEPTH-entry FIFO and issues at most one register-file write per cycle on REG_EN / REG_W_ADR / REG_W_DATA.
- Exports a pending-destination mask so hazard logic can stall readers of registers with writes still in flight.

---
 rtl/regfile_writeback_queue.sv | 116 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Merges ALU (priority) and load/mul write-backs into an in-order FIFO that drains one register-file write per cycle.
// Write presented one cycle after acceptance; READY drops only when the FIFO is full (B also yields to A).
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_a_valid,
  input  logic [4:0]                 i_a_rd,
  input  logic [31:0]                i_a_data,
  output logic                       o_a_ready,
  input  logic                       i_b_valid,
  input  logic [4:0]                 i_b_rd,
  input  logic [31:0]                i_b_data,
  output logic                       o_b_ready,
  input  logic                       i_drain_en,
  output logic                       o_reg_en,
  output logic [4:0]                 o_reg_w_adr,
  output logic [31:0]                o_reg_w_data,
  output logic [31:0]                o_pend,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_reg_en;
  logic [4:0]       r_reg_w_adr;
  logic [31:0]      r_reg_w_data;

  logic             w_full;
  logic             w_empty;
  logic             w_a_acc;
  logic             w_b_acc;
  logic [4:0]       w_acc_rd;
  logic [31:0]      w_acc_data;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_pend;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign o_a_ready = !w_full;
  assign o_b_ready = !w_full && !i_a_valid;

  assign w_a_acc    = i_a_valid && !w_full;
  assign w_b_acc    = i_b_valid && !w_full && !i_a_valid;
  assign w_acc_rd   = w_a_acc ? i_a_rd   : i_b_rd;
  assign w_acc_data = w_a_acc ? i_a_data : i_b_data;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_push     = (w_a_acc || w_b_acc) && (w_acc_rd != 5'd0);
  assign w_pop      = i_drain_en && !w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_vld        <= '0;
      r_reg_en     <= 1'b0;
      r_reg_w_adr  <= 5'd0;
      r_reg_w_data <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      if (w_pop) begin
        r_reg_en      <= 1'b1;
        r_reg_w_adr   <= r_rd[r_head];
        r_reg_w_data  <= r_data[r_head];
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end else begin
        r_reg_en <= 1'b0;
      end

      // Push and pop never share a slot: a pop needs a non-empty FIFO, so tail != head unless full.
      if (w_push) begin
        r_rd[r_tail]   <= w_acc_rd;
        r_data[r_tail] <= w_acc_data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_pend = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pend[r_rd[i]] = 1'b1;
    end
    if (r_reg_en) w_pend[r_reg_w_adr] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign o_pend       = w_pend;
  assign o_reg_en     = r_reg_en;
  assign o_reg_w_adr  = r_reg_w_adr;
  assign o_reg_w_data = r_reg_w_data;
  assign o_count      = r_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench with a queue-based reference model checked every cycle, plus literal spot checks.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid = 1'b0, b_valid = 1'b0, drain = 1'b0;
  logic [4:0]  a_rd = 5'd0, b_rd = 5'd0;
  logic [31:0] a_data = 32'd0, b_data = 32'd0;
  logic        a_ready, b_ready, reg_en;
  logic [4:0]  reg_adr;
  logic [31:0] reg_dat, pend;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_drain_en(drain),
    .o_reg_en(reg_en), .o_reg_w_adr(reg_adr), .o_reg_w_data(reg_dat),
    .o_pend(pend), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending {rd,data} plus the presented write.
  logic [36:0] mq[$];
  logic        m_en;
  logic [4:0]  m_adr;
  logic [31:0] m_dat;
  bit          m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_en  = 1'b0;
      m_adr = 5'd0;
      m_dat = 32'd0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (drain && mq.size() > 0) begin
        {m_adr, m_dat} = mq.pop_front();
        m_en = 1'b1;
      end else begin
        m_en = 1'b0;
      end
      if (!m_full) begin
        if (a_valid) begin
          if (a_rd != 5'd0) mq.push_back({a_rd, a_data});
        end else if (b_valid) begin
          if (b_rd != 5'd0) mq.push_back({b_rd, b_data});
        end
      end
    end
  end

  function automatic logic [31:0] model_pend();
    logic [31:0] p = 32'd0;
    foreach (mq[i]) p[mq[i][36:32]] = 1'b1;
    if (m_en) p[m_adr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(negedge clk) begin
    #1;
    chk("m_reg_en",  {31'd0, reg_en}, {31'd0, m_en});
    chk("m_reg_adr", {27'd0, reg_adr}, {27'd0, m_adr});
    chk("m_reg_dat", reg_dat, m_dat);
    chk("m_count",   {29'd0, count}, mq.size());
    chk("m_pend",    pend, model_pend());
    chk("m_a_ready", {31'd0, a_ready}, {31'd0, (mq.size() != DEPTH)});
    chk("m_b_ready", {31'd0, b_ready}, {31'd0, (mq.size() != DEPTH) && !a_valid});
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) nxt();
    settle();
    chk("rst_reg_en", {31'd0, reg_en}, 32'd0);
    chk("rst_count",  {29'd0, count}, 32'd0);
    chk("rst_pend",   pend, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
    rst = 1'b0;

    // Single write, empty FIFO, drain enabled
    nxt(); a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; drain = 1;
    nxt(); a_valid = 0;
    settle(); chk("t1_count", {29'd0, count}, 32'd1); chk("t1_pend_q", pend, 32'h20);
    nxt(); settle();
    chk("t1_en", {31'd0, reg_en}, 32'd1);
    chk("t1_adr", {27'd0, reg_adr}, 32'd5);
    chk("t1_dat", reg_dat, 32'hDEADBEEF);
    nxt(); settle();
    chk("t1_en_off", {31'd0, reg_en}, 32'd0);
    chk("t1_pend_off", pend, 32'd0);

    // A/B tie: A wins, B follows next cycle
    nxt(); a_valid = 1; a_rd = 3; a_data = 32'h33; b_valid = 1; b_rd = 4; b_data = 32'h44;
    settle(); chk("t2_b_ready_tie", {31'd0, b_ready}, 32'd0);
    nxt(); a_valid = 0;
    settle(); chk("t2_b_ready", {31'd0, b_ready}, 32'd1);
    nxt(); b_valid = 0;
    settle(); chk("t2_first_adr", {27'd0, reg_adr}, 32'd3); chk("t2_first_en", {31'd0, reg_en}, 32'd1);
    nxt(); settle();
    chk("t2_second_adr", {27'd0, reg_adr}, 32'd4); chk("t2_second_dat", reg_dat, 32'h44);
    nxt();

    // Fill with drain disabled, then release
    drain = 0;
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1; a_rd = 5'(i); a_data = 32'h100 * i;
      nxt();
    end
    a_rd = 5; a_data = 32'h500;
    settle();
    chk("t3_count_full", {29'd0, count}, 32'd4);
    chk("t3_a_ready_full", {31'd0, a_ready}, 32'd0);
    chk("t3_pend_full", pend, 32'h1E);
    nxt(); drain = 1;
    nxt(); settle();
    chk("t3_pop_adr", {27'd0, reg_adr}, 32'd1);
    chk("t3_a_ready_after_pop", {31'd0, a_ready}, 32'd1);
    nxt(); a_valid = 0;
    repeat (6) nxt();

    // x0 filter
    a_valid = 1; a_rd = 0; a_data = 32'h1234;
    settle(); chk("t4_a_ready", {31'd0, a_ready}, 32'd1);
    nxt(); a_valid = 0;
    settle(); chk("t4_count", {29'd0, count}, 32'd0);
    nxt(); settle();
    chk("t4_no_en", {31'd0, reg_en}, 32'd0); chk("t4_pend", pend, 32'd0);

    // Two queued writes to x7
    nxt(); drain = 0; a_valid = 1; a_rd = 7; a_data = 32'h11;
    nxt(); a_data = 32'h22;
    nxt(); a_valid = 0; drain = 1;
    settle(); chk("t5_count", {29'd0, count}, 32'd2); chk("t5_pend_q", pend, 32'h80);
    nxt(); settle(); chk("t5_first", reg_dat, 32'h11); chk("t5_pend1", pend, 32'h80);
    nxt(); settle(); chk("t5_second", reg_dat, 32'h22); chk("t5_pend2", pend, 32'h80);
    nxt(); settle(); chk("t5_en_off", {31'd0, reg_en}, 32'd0); chk("t5_pend_off", pend, 32'd0);

    // Reset mid-stream with a write presented and three queued
    nxt(); drain = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'(9 + i); a_data = 32'hA0 + i;
      nxt();
    end
    a_valid = 0; drain = 1;
    nxt(); drain = 0;
    settle();
    chk("t6_pre_count", {29'd0, count}, 32'd3);
    chk("t6_pre_en", {31'd0, reg_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_en", {31'd0, reg_en}, 32'd0);
    chk("t6_rst_count", {29'd0, count}, 32'd0);
    chk("t6_rst_pend", pend, 32'd0);
    nxt(); rst = 1'b0; drain = 1;
    repeat (4) begin
      nxt(); settle();
      chk("t6_quiet_en", {31'd0, reg_en}, 32'd0);
    end

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
